// File: rtl/user_ram_bridge_pkg.sv
// Shared types and constants for the CPU-to-user-RAM bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package user_ram_bridge_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ISS = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_MW_ISS = 3'd3,
    ST_MW_CAP = 3'd4,
    ST_WR     = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  // Byte-strobe patterns that select the read and full-write paths.
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_FULL = 4'b1111;

  // RAM read data appears this many cycles after the read enable rises.
  localparam int RAM_RD_LAT = 1;

  // States in which the RAM read enable is asserted.
  function automatic logic is_rd_state(input state_e s);
    return (s == ST_RD_ISS) || (s == ST_RD_CAP) ||
           (s == ST_MW_ISS) || (s == ST_MW_CAP);
  endfunction

endpackage

// File: rtl/user_ram_byte_merge.sv
// Byte-lane merge of new write data over an old RAM word.
// Latency: combinational.
// Backpressure: none.
module user_ram_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);

  // Each lane takes the new byte where its strobe is set, else keeps the old byte.
  always_comb begin
    merged_o = old_i;
    for (int k = 0; k < 4; k++) begin
      if (strb_i[k]) begin
        merged_o[8*k +: 8] = new_i[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/user_ram_bridge.sv
// CPU native-bus slave for the word-only user RAM; sub-word stores via read-modify-write.
// Latency: ready 3 cycles after hit for reads, 2 for full writes, 4 for partial writes.
// Backpressure: one request in flight; a new request is accepted only in IDLE.
module user_ram_bridge
  import user_ram_bridge_pkg::*;
#(
  parameter int          ADDR_BIT  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mem_valid_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i,
  output logic                busy_o
);

  state_e              state_q;
  logic [ADDR_BIT-1:0] addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic [31:0]         di_q;
  logic [31:0]         rdata_q;
  logic [31:0]         merged;
  logic                hit;

  // The RAM is word-addressed, so the byte offset carries no information here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // Address window decode; only upper bits are compared since the window is aligned.
  assign hit = mem_valid_i && (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);

  // Old word comes straight from the RAM during MW_CAP, new bytes from the latched request.
  user_ram_byte_merge u_merge (
    .old_i    (ram_do_i),
    .new_i    (wdata_q),
    .strb_i   (wstrb_q),
    .merged_o (merged)
  );

  // Sequencer: latches the request on a hit and walks the read / write / RMW paths.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      di_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            addr_q  <= mem_addr_i[ADDR_BIT+1:2];
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            // Full writes go out as-is; partial writes overwrite this after the merge.
            di_q    <= mem_wdata_i;
            if (mem_wstrb_i == STRB_NONE) begin
              state_q <= ST_RD_ISS;
            end else if (mem_wstrb_i == STRB_FULL) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_MW_ISS;
            end
          end
        end
        ST_RD_ISS: state_q <= ST_RD_CAP;
        ST_RD_CAP: begin
          rdata_q <= ram_do_i;
          state_q <= ST_RESP;
        end
        ST_MW_ISS: state_q <= ST_MW_CAP;
        ST_MW_CAP: begin
          di_q    <= merged;
          state_q <= ST_WR;
        end
        ST_WR:   state_q <= ST_RESP;
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Enables and handshake are pure state decodes, so they cannot overlap or glitch on inputs.
  assign ram_rd_en_o = is_rd_state(state_q);
  assign ram_wr_en_o = (state_q == ST_WR);
  assign mem_ready_o = (state_q == ST_RESP);
  assign busy_o      = (state_q != ST_IDLE);
  assign ram_addr_o  = addr_q;
  assign ram_di_o    = di_q;
  assign mem_rdata_o = rdata_q;

endmodule

// File: doc/user_ram_bridge.md
Name: user_ram_bridge

Overview:
- Slave adapter between the CPU native memory bus (valid/ready, 32-bit address, byte strobes) and the word-only, single-port user RAM.
- Sits directly upstream of the RAM: decodes its address window, sequences the RAM enables, and returns read data to the CPU.
- Sub-word stores are done by read-modify-write, because the RAM has no byte enables.

Parameters:
- ADDR_BIT, 8, RAM word-address width; the window holds 2^ADDR_BIT words (4*2^ADDR_BIT bytes).
- BASE_ADDR, 32'h0200_0000, byte base of the window; must be aligned to 4*2^ADDR_BIT.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-low
- mem_valid_i  in  1  CPU request valid
- mem_addr_i  in  32  CPU byte address
- mem_wdata_i  in  32  CPU write data
- mem_wstrb_i  in  4  byte strobes; 0000 means read
- mem_ready_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1, held afterwards
- ram_wr_en_o  out  1  RAM write enable
- ram_rd_en_o  out  1  RAM read enable
- ram_addr_o  out  ADDR_BIT  RAM word address
- ram_di_o  out  32  RAM write data
- ram_do_i  in  32  RAM read data; valid one cycle after ram_rd_en_o rises, only while ram_rd_en_o stays high
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state goes to IDLE.
  - All outputs go to 0, including mem_rdata_o=0 and ram_addr_o=0.
  - The latched request registers are cleared.
  - Reset mid-transaction aborts it: no mem_ready_o pulse, no RAM write.
- Window hit: hit = mem_valid_i && mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2].
  - Word address = mem_addr_i[ADDR_BIT+1:2]; mem_addr_i[1:0] is ignored.
  - Non-hit requests are ignored entirely (another slave answers): no ready, no RAM activity.
- Capture: in IDLE on a hit, word address, wdata and wstrb are latched. Later changes on mem_*_i are ignored until RESP.
- States: IDLE, RD_ISS, RD_CAP, MW_ISS, MW_CAP, WR, RESP.
- Read (wstrb=0000):
  - Path: IDLE → RD_ISS → RD_CAP → RESP.
  - ram_rd_en_o=1 and ram_addr_o held through RD_ISS and RD_CAP.
  - ram_do_i is registered into mem_rdata_o at the end of RD_CAP.
  - mem_ready_o=1 in RESP, i.e. 3 cycles after the hit cycle.
- Full write (wstrb=1111):
  - Path: IDLE → WR → RESP.
  - In WR: ram_wr_en_o=1, ram_di_o=wdata.
  - Ready 2 cycles after the hit cycle.
- Partial write (any other nonzero wstrb):
  - Path: IDLE → MW_ISS → MW_CAP → WR → RESP.
  - The word is read as in the read path.
  - Merge rule: merged byte k = wstrb[k] ? wdata byte k : old byte k.
  - The merged word is written in WR.
  - Ready 4 cycles after the hit cycle.
  - mem_rdata_o is unchanged by writes.
- RESP:
  - mem_ready_o=1 for exactly one cycle, then the state returns to IDLE.
  - No new request is accepted in the RESP cycle itself. A request still high in the following IDLE cycle is treated as a new transaction (CPU protocol drops valid after ready).
- Enable exclusivity: ram_wr_en_o and ram_rd_en_o are never high in the same cycle. Both are 0 in IDLE and RESP.
- mem_valid_i dropping mid-transaction (protocol violation): the transaction still completes, including the write and the ready pulse.
- All outputs are registered or decoded from state only; there is no combinational path from mem_*_i to ram_*_o.

Decomposition:
- Package user_ram_bridge_pkg holds:
  - State encoding constants.
  - STRB_NONE=4'b0000 and STRB_FULL=4'b1111.
  - Read latency constant RAM_RD_LAT=1.
- One natural sub-module: user_ram_byte_merge (combinational; inputs old[31:0], new[31:0], strb[3:0]; output merged[31:0]).

Test Plan:
- Preload RAM word 5 = 32'hDEAD_BEEF; read at 32'h0200_0014 → ready in cycle 3 after hit, mem_rdata_o=32'hDEAD_BEEF, ram_rd_en_o high exactly 2 cycles.
- Full write 32'h1234_5678 at 32'h0200_0020, then read back → ready 2 cycles after hit; word 8 = 32'h1234_5678; no ram_rd_en_o during the write.
- Word 3 = 32'hAABB_CCDD; write wdata 32'h1122_3344 with wstrb=4'b0101 → word 3 = 32'hAA22_CC44, ready 4 cycles after hit.
- Request at 32'h0300_0000 → no mem_ready_o and no RAM enables for 10 cycles; busy_o stays 0.
- Assert rst_i=0 during MW_CAP of a partial write → outputs 0 immediately; the RAM word is unchanged; after release, a fresh read returns the old value.
- Back-to-back: keep valid high through RESP with a new address → exactly one ready per transaction, the second starting in the IDLE cycle after RESP.
